// File: rtl/tone_pkg.sv
// Shared note codes, half-period table and player state encoding for the
// melody player and the manual-piano top.
package tone_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C2   = 4'd1;
    localparam logic [3:0] NOTE_D2   = 4'd2;
    localparam logic [3:0] NOTE_E2   = 4'd3;
    localparam logic [3:0] NOTE_F2   = 4'd4;
    localparam logic [3:0] NOTE_G2   = 4'd5;
    localparam logic [3:0] NOTE_A2   = 4'd6;
    localparam logic [3:0] NOTE_B2   = 4'd7;
    localparam logic [3:0] NOTE_C3   = 4'd8;

    localparam int HALF_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] dur;
    } song_entry_t;

    // Half period in clk cycles at 1 MHz; rest maps to 0 and is never counted.
    function automatic logic [HALF_W-1:0] half_cycles(input logic [3:0] code);
        case (code)
            NOTE_C2: half_cycles = 11'd1912;
            NOTE_D2: half_cycles = 11'd1703;
            NOTE_E2: half_cycles = 11'd1517;
            NOTE_F2: half_cycles = 11'd1431;
            NOTE_G2: half_cycles = 11'd1275;
            NOTE_A2: half_cycles = 11'd1136;
            NOTE_B2: half_cycles = 11'd1012;
            NOTE_C3: half_cycles = 11'd955;
            default: half_cycles = '0;
        endcase
    endfunction

    // Only a single pressed key produces a tone; chords and no-key are silent.
    function automatic logic [3:0] key_to_note(input logic [7:0] keys);
        case (keys)
            8'h01:   key_to_note = NOTE_C2;
            8'h02:   key_to_note = NOTE_D2;
            8'h04:   key_to_note = NOTE_E2;
            8'h08:   key_to_note = NOTE_F2;
            8'h10:   key_to_note = NOTE_G2;
            8'h20:   key_to_note = NOTE_A2;
            8'h40:   key_to_note = NOTE_B2;
            8'h80:   key_to_note = NOTE_C3;
            default: key_to_note = NOTE_REST;
        endcase
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles its level every half_cycles(note) clocks,
// silent on rest, and restarts the count whenever the note changes.
module tone_gen
    import tone_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] note,
    output logic       piezo
);

    logic [HALF_W-1:0] cnt;
    logic [HALF_W-1:0] half_last;
    logic [3:0]        last_note;
    logic              level;

    assign half_last = half_cycles(note) - 1'b1;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            last_note <= NOTE_REST;
            level     <= 1'b0;
        end else begin
            last_note <= note;
            if (note == NOTE_REST) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (note != last_note) begin
                cnt <= '0;
            end else if (cnt == half_last) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Gate with the live note so a rest silences the buzzer without a cycle of lag.
    assign piezo = level & (note != NOTE_REST);

endmodule

// File: rtl/melody_player.sv
// Song player with manual keys: plays a fixed song table on start, otherwise
// sounds the single pressed key. Tone synthesis is delegated to tone_gen.
module melody_player
    import tone_pkg::*;
#(
    parameter int TICK_DIV = 250000,
    parameter int GAP_CYC  = 20000,
    parameter int SONG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    input  logic       start,
    input  logic       stop,
    output logic       piezo,
    output logic       busy,
    output logic       done,
    output logic [3:0] note
);

    localparam int DUR_W = 21;
    localparam int IDX_W = 4;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [DUR_W-1:0] TICK     = DUR_W'(TICK_DIV);

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [DUR_W-1:0]  dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    song_entry_t       entry;
    logic [2:0]        dur_eff;
    logic [DUR_W-1:0]  dur_last_cnt;
    logic              dur_last;
    logic              gap_last;
    logic              more_notes;

    // NOTE: a constant ROM is pure decode logic, so it has no reset.
    always_comb begin
        entry = {NOTE_REST, 3'd1};
        case (idx)
            4'd0:  entry = {NOTE_E2,   3'd2};
            4'd1:  entry = {NOTE_REST, 3'd1};
            4'd2:  entry = {NOTE_E2,   3'd1};
            4'd3:  entry = {NOTE_F2,   3'd1};
            4'd4:  entry = {NOTE_G2,   3'd1};
            4'd5:  entry = {NOTE_G2,   3'd1};
            4'd6:  entry = {NOTE_F2,   3'd1};
            4'd7:  entry = {NOTE_E2,   3'd1};
            4'd8:  entry = {NOTE_D2,   3'd1};
            4'd9:  entry = {NOTE_C2,   3'd1};
            4'd10: entry = {NOTE_C2,   3'd1};
            4'd11: entry = {NOTE_D2,   3'd1};
            4'd12: entry = {NOTE_E2,   3'd1};
            4'd13: entry = {NOTE_E2,   3'd3};
            4'd14: entry = {NOTE_D2,   3'd0};
            4'd15: entry = {NOTE_D2,   3'd2};
            default: entry = {NOTE_REST, 3'd1};
        endcase
    end

    assign dur_eff      = (entry.dur == 3'd0) ? 3'd1 : entry.dur;
    assign dur_last_cnt = DUR_W'(dur_eff) * TICK - 1'b1;
    assign dur_last     = (dur_cnt == dur_last_cnt);
    assign gap_last     = (gap_cnt == GAP_LAST);
    assign more_notes   = (idx < LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first keeps this block combinational and latch-free.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_PLAY;
            ST_PLAY: begin
                if (stop)          state_next = ST_IDLE;
                else if (dur_last) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (stop)          state_next = ST_IDLE;
                else if (gap_last) state_next = more_notes ? ST_PLAY : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        note = NOTE_REST;
        case (state)
            ST_IDLE: note = key_to_note(btn);
            ST_PLAY: note = entry.code;
            default: note = NOTE_REST;
        endcase
    end

    // Song position, duration/gap counters and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE || stop) begin
                idx     <= '0;
                dur_cnt <= '0;
                gap_cnt <= '0;
            end else if (state == ST_PLAY) begin
                dur_cnt <= dur_last ? '0 : dur_cnt + 1'b1;
            end else if (gap_last) begin
                gap_cnt <= '0;
                if (more_notes) begin
                    idx <= idx + 1'b1;
                end else begin
                    idx  <= '0;
                    done <= 1'b1;
                end
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    tone_gen u_tone_gen (
        .clk   (clk),
        .rst   (rst),
        .note  (note),
        .piezo (piezo)
    );

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with a two-entry song: {E2,dur2},{rest,dur1},
// ten cycles per duration unit and a three-cycle gap.
module tb_melody_player;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn;
    logic       start;
    logic       stop;
    logic       piezo;
    logic       busy;
    logic       done;
    logic [3:0] note;

    int total = 0;
    int bad   = 0;
    int n;

    melody_player #(
        .TICK_DIV (10),
        .GAP_CYC  (3),
        .SONG_LEN (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .start (start),
        .stop  (stop),
        .piezo (piezo),
        .busy  (busy),
        .done  (done),
        .note  (note)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic b, input logic d, input logic [3:0] nt);
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " note"}, 32'(note), 32'(nt));
    endtask

    // Count clock edges until piezo reaches the given level, bounded at 4000.
    task automatic wait_piezo(input logic level, output int cycles);
        cycles = 0;
        while (piezo !== level && cycles < 4000) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; btn = 8'h00; start = 1'b0; stop = 1'b0;
        repeat (3) step();
        check_out("reset", 1'b0, 1'b0, 4'd0);
        check("reset piezo", 32'(piezo), 32'd0);

        rst = 1'b0;
        step();
        check_out("idle no key", 1'b0, 1'b0, 4'd0);

        // Key decode: single keys map to codes, then hold E2.
        btn = 8'h80; #1; check("key C3", 32'(note), 32'd8);
        btn = 8'h01; #1; check("key C2", 32'(note), 32'd1);
        btn = 8'h04; #1; check("key E2", 32'(note), 32'd3);
        check("key E2 piezo start", 32'(piezo), 32'd0);

        wait_piezo(1'b1, n);
        check("E2 first rise", 32'(piezo), 32'd1);
        wait_piezo(1'b0, n);
        check("E2 half period fall", 32'(n), 32'd1517);
        wait_piezo(1'b1, n);
        check("E2 half period rise", 32'(n), 32'd1517);

        // Switch to G2 while high: level holds, count restarts on the next edge.
        btn = 8'h10; #1;
        check("key G2", 32'(note), 32'd5);
        check("G2 keeps level", 32'(piezo), 32'd1);
        wait_piezo(1'b0, n);
        check("G2 restart fall", 32'(n), 32'd1276);
        wait_piezo(1'b1, n);
        check("G2 half period rise", 32'(n), 32'd1275);

        // Two keys at once: silent immediately.
        btn = 8'h05; #1;
        check("chord note", 32'(note), 32'd0);
        check("chord piezo", 32'(piezo), 32'd0);
        step();
        check("chord piezo held", 32'(piezo), 32'd0);
        btn = 8'h00;

        // Full song: 20 cycles E2, 3 gap, 10 rest, 3 gap, then done.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 36; c++) begin
            check_out($sformatf("song c%0d", c), 1'b1, 1'b0, (c < 20) ? 4'd3 : 4'd0);
            step();
        end
        check_out("song end", 1'b0, 1'b1, 4'd0);
        step();
        check_out("song after done", 1'b0, 1'b0, 4'd0);

        // Stop on the fifth play cycle.
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        check_out("stop5 before", 1'b1, 1'b0, 4'd3);
        stop = 1'b1; step(); stop = 1'b0;
        check_out("stop5 after", 1'b0, 1'b0, 4'd0);
        check("stop5 piezo", 32'(piezo), 32'd0);
        step();
        check_out("stop5 idle", 1'b0, 1'b0, 4'd0);

        // Stop wins over duration expiry on the last play cycle.
        start = 1'b1; step(); start = 1'b0;
        repeat (19) step();
        check_out("stop19 before", 1'b1, 1'b0, 4'd3);
        stop = 1'b1; step(); stop = 1'b0;
        check_out("stop19 after", 1'b0, 1'b0, 4'd0);

        // Stop on the final gap cycle suppresses done.
        start = 1'b1; step(); start = 1'b0;
        repeat (35) step();
        check_out("stop35 before", 1'b1, 1'b0, 4'd0);
        stop = 1'b1; step(); stop = 1'b0;
        check_out("stop35 after", 1'b0, 1'b0, 4'd0);
        step();
        check_out("stop35 idle", 1'b0, 1'b0, 4'd0);

        // Start wins over a held key; keys and start are ignored while playing.
        btn = 8'h01; start = 1'b1; #1;
        check("held key idle", 32'(note), 32'd1);
        step();
        check_out("held c0", 1'b1, 1'b0, 4'd3);
        repeat (10) step();
        check_out("held c10", 1'b1, 1'b0, 4'd3);
        start = 1'b0;
        repeat (15) step();
        check_out("held c25", 1'b1, 1'b0, 4'd0);
        repeat (11) step();
        check_out("held end", 1'b0, 1'b1, 4'd1);
        btn = 8'h00;
        step();

        // Reset in the second gap clears everything at once; restart plays idx 0.
        start = 1'b1; step(); start = 1'b0;
        repeat (34) step();
        check_out("rst gap before", 1'b1, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        check_out("rst async", 1'b0, 1'b0, 4'd0);
        check("rst async piezo", 32'(piezo), 32'd0);
        step();
        check_out("rst held", 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        rst = 1'b0;
        step();
        start = 1'b0;
        check_out("restart c0", 1'b1, 1'b0, 4'd3);
        repeat (20) step();
        check_out("restart c20", 1'b1, 1'b0, 4'd0);
        stop = 1'b1; step(); stop = 1'b0;
        check_out("restart stopped", 1'b0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter TICK_DIV, default 250000, means clk cycles per duration unit (250 ms at 1 MHz).
REQ-002 Parameter GAP_CYC, default 20000, means silent clk cycles inserted after every song note.
REQ-003 Parameter SONG_LEN, default 16, means number of entries in the internal song table (1..16).
REQ-004 Port clk, input, 1, is the single 1 MHz clock; all logic is in this one clock domain.
REQ-005 Port rst, input, 1, is the asynchronous, active-high reset.
REQ-006 Port btn, input, 8, is the manual keys; bit0..bit7 select C2,D2,E2,F2,G2,A2,B2,C3.
REQ-007 Port start, input, 1, is a level request to begin song playback.
REQ-008 Port stop, input, 1, is a level request to abort playback.
REQ-009 Port piezo, output, 1, is the square-wave drive to the buzzer.
REQ-010 Port busy, output, 1, is high while a song is playing.
REQ-011 Port done, output, 1, is a one-cycle pulse on natural song completion.
REQ-012 Port note, output, 4, is the current note code: 0 = rest, 1..8 = C2..C3.

Function
REQ-013 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-014 In IDLE, note SHALL be 1..8 when btn is exactly one-hot (bit0 gives 1, bit7 gives 8); for any other btn value, including zero or multiple bits, note SHALL be 0.
REQ-015 In IDLE with start=1, the block SHALL move to PLAY with idx=0 on the next edge, and start SHALL take priority over btn.
REQ-016 Each song table entry SHALL be {code[3:0], dur[2:0]}, and dur=0 SHALL be treated as 1.
REQ-017 In PLAY, note SHALL equal the table code for idx for exactly dur*TICK_DIV cycles, then the FSM SHALL move to GAP.
REQ-018 In GAP, note SHALL be 0 for exactly GAP_CYC cycles.
REQ-019 At the end of GAP, if idx<SONG_LEN-1, idx SHALL increment and the FSM SHALL move to PLAY; otherwise it SHALL move to IDLE and pulse done for one cycle.
REQ-020 In PLAY or GAP, btn and start SHALL be ignored.
REQ-021 If stop=1 in PLAY or GAP, the FSM SHALL go to IDLE on the next edge with no done pulse, and idx and all counters SHALL clear; stop has priority over duration expiry on the same cycle.
REQ-022 busy SHALL be 1 exactly in PLAY and GAP.
REQ-023 The tone generator SHALL toggle piezo every HALF[note] cycles, with HALF = 1912,1703,1517,1431,1275,1136,1012,955 for notes 1..8.
REQ-024 When note=0, piezo SHALL be held at 0 and the tone counter SHALL clear.
REQ-025 On any change of note, the tone counter SHALL restart from 0 while piezo keeps its current level.
REQ-026 The duration counter SHALL be 21 bits; the gap counter SHALL be wide enough for GAP_CYC-1 with no wrap.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, idx=0, all counters=0, piezo=0, busy=0, done=0.
REQ-028 In IDLE with btn=0, note SHALL be 0.
REQ-029 Reset asserted mid-song SHALL abort with no done pulse.
REQ-030 After rst falls, the first edge SHALL evaluate normal IDLE behaviour.

Structure
REQ-031 The note code constants, the HALF table and the state encoding SHALL live in a shared package, tone_pkg.
REQ-032 Sub-module tone_gen (clk, rst, note[3:0], piezo) SHALL implement REQ-023 to REQ-025 and be reused by the manual-piano top.
REQ-033 The song table SHALL be a constant case ROM inside melody_player.

Verification (TICK_DIV=10, GAP_CYC=3, SONG_LEN=2, table = {E2,dur2},{rest,dur1})
REQ-034 Apply btn=8'b00000100 in IDLE -> note=3, and piezo toggles every 1517 cycles.
REQ-035 Apply btn=8'b00000101 -> note=0 and piezo=0.
REQ-036 Pulse start for 1 cycle -> busy=1, note=3 for 20 cycles, note=0 for 3, note=0 for 10, note=0 for 3, then done pulses once and busy=0 (36 cycles total).
REQ-037 Assert stop at cycle 5 of PLAY -> IDLE next edge, busy=0, no done, and piezo=0 follows.
REQ-038 Hold btn=8'b00000001 plus start -> song starts, and btn is ignored until IDLE.
REQ-039 Assert rst mid-GAP -> all outputs go to 0 immediately, and a restart begins at idx 0.
